// File: rtl/cu_pkg.sv
// cu_pkg: shared types and constants for the param_control_unit datapath and FSM.
// Covers FSM states, ALU operations, opcodes and register-reference bit indices.
package cu_pkg;
    typedef enum logic [2:0] {S_FETCH, S_DECODE, S_INDIR, S_EXEC, S_WB, S_HALT} state_e;
    typedef enum logic [3:0] {
        A_NOP, A_AND, A_ADD, A_LDA, A_CLA, A_CLE, A_CMA, A_CME, A_CIR, A_CIL, A_INC
    } alu_op_e;
    localparam logic [2:0] OP_AND = 3'd0;
    localparam logic [2:0] OP_ADD = 3'd1;
    localparam logic [2:0] OP_LDA = 3'd2;
    localparam logic [2:0] OP_STA = 3'd3;
    localparam logic [2:0] OP_BUN = 3'd4;
    localparam logic [2:0] OP_BSA = 3'd5;
    localparam logic [2:0] OP_ISZ = 3'd6;
    localparam logic [2:0] OP_REG = 3'd7;
    localparam logic [3:0] RR_CLA = 4'd11;
    localparam logic [3:0] RR_CLE = 4'd10;
    localparam logic [3:0] RR_CMA = 4'd9;
    localparam logic [3:0] RR_CME = 4'd8;
    localparam logic [3:0] RR_CIR = 4'd7;
    localparam logic [3:0] RR_CIL = 4'd6;
    localparam logic [3:0] RR_INC = 4'd5;
    localparam logic [3:0] RR_SPA = 4'd4;
    localparam logic [3:0] RR_SNA = 4'd3;
    localparam logic [3:0] RR_SZA = 4'd2;
    localparam logic [3:0] RR_SZE = 4'd1;
    localparam logic [3:0] RR_HLT = 4'd0;
    // Index of the highest set register-reference bit; 15 when none is set.
    function automatic logic [3:0] rr_sel(input logic [11:0] b);
        rr_sel = 4'hF;
        for (int i = 0; i < 12; i++)
            if (b[i]) rr_sel = 4'(i);
    endfunction
endpackage

// File: rtl/param_control_unit_if.sv
// param_control_unit_if: single-port memory bus between the control unit and memory.
interface param_control_unit_if #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 8
);
    logic              mem_req;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;
    logic              mem_ack;
    modport master (output mem_req, mem_we, mem_addr, mem_wdata, input mem_rdata, mem_ack);
    modport slave  (input mem_req, mem_we, mem_addr, mem_wdata, output mem_rdata, mem_ack);
endinterface

// File: rtl/cu_alu.sv
// cu_alu: combinational accumulator/E-flag unit for memory and register-reference operations.
module cu_alu
    import cu_pkg::*;
#(
    parameter int DATA_W = 16
) (
    input  logic [DATA_W-1:0] i_ac,
    input  logic [DATA_W-1:0] i_opd,
    input  logic              i_e,
    input  alu_op_e           i_op,
    output logic [DATA_W-1:0] o_ac,
    output logic              o_e
);
    logic [DATA_W:0] w_sum;
    assign w_sum = {1'b0, i_ac} + {1'b0, i_opd};
    always_comb begin
        o_ac = i_ac;
        o_e  = i_e;
        case (i_op)
            A_AND: o_ac = i_ac & i_opd;
            A_ADD: {o_e, o_ac} = w_sum;
            A_LDA: o_ac = i_opd;
            A_CLA: o_ac = '0;
            A_CLE: o_e = 1'b0;
            A_CMA: o_ac = ~i_ac;
            A_CME: o_e = ~i_e;
            A_CIR: {o_ac, o_e} = {i_e, i_ac};
            A_CIL: {o_e, o_ac} = {i_ac, i_e};
            A_INC: o_ac = i_ac + DATA_W'(1);
            default: ;
        endcase
    end
endmodule

// File: rtl/param_control_unit.sv
// param_control_unit: multi-cycle accumulator-machine control unit (fetch/decode/indirect/execute/writeback)
// issuing one request/ack memory transaction at a time over a shared bus.
module param_control_unit
    import cu_pkg::*;
#(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 8,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 en,
    param_control_unit_if.master mem,
    output logic [DATA_W-1:0]    ac_out,
    output logic [ADDR_W-1:0]    pc_out,
    output logic                 e_out,
    output logic                 halted,
    output logic                 instr_done
);
    state_e            r_state, w_state_nx;
    logic [ADDR_W-1:0] r_pc, w_pc_nx, r_ar, w_ar_nx, r_addr, w_addr_nx, w_go_addr;
    logic [DATA_W-1:0] r_ac, w_ac_nx, r_dr, w_dr_nx, r_ir, w_ir_nx, r_wdata, w_wdata_nx;
    logic [DATA_W-1:0] w_go_wdata, w_alu_ac;
    logic              r_e, w_e_nx, r_req, w_req_nx, r_we, w_we_nx, r_done, w_done_nx;
    logic              w_go, w_go_we, w_alu_e, w_ack, w_i, w_skip;
    logic [2:0]        w_opc;
    logic [3:0]        w_rr;
    alu_op_e           w_alu_op;

    assign w_i    = r_ir[DATA_W-1];
    assign w_opc  = r_ir[DATA_W-2:DATA_W-4];
    assign w_rr   = rr_sel(r_ir[11:0]);
    assign w_ack  = r_req & mem.mem_ack;
    assign w_skip = !w_i && ((w_rr == RR_SPA && !r_ac[DATA_W-1]) ||
                             (w_rr == RR_SNA &&  r_ac[DATA_W-1]) ||
                             (w_rr == RR_SZA && r_ac == '0) ||
                             (w_rr == RR_SZE && !r_e));
    assign w_alu_op = (w_opc == OP_AND) ? A_AND :
                      (w_opc == OP_ADD) ? A_ADD :
                      (w_opc == OP_LDA) ? A_LDA :
                      (w_opc != OP_REG || w_i) ? A_NOP :
                      (w_rr == RR_CLA) ? A_CLA :
                      (w_rr == RR_CLE) ? A_CLE :
                      (w_rr == RR_CMA) ? A_CMA :
                      (w_rr == RR_CME) ? A_CME :
                      (w_rr == RR_CIR) ? A_CIR :
                      (w_rr == RR_CIL) ? A_CIL :
                      (w_rr == RR_INC) ? A_INC : A_NOP;

    cu_alu #(.DATA_W(DATA_W)) u_alu (
        .i_ac  (r_ac),
        .i_opd (mem.mem_rdata),
        .i_e   (r_e),
        .i_op  (w_alu_op),
        .o_ac  (w_alu_ac),
        .o_e   (w_alu_e)
    );

    always_comb begin
        w_state_nx = r_state;
        w_pc_nx    = r_pc;
        w_ar_nx    = r_ar;
        w_ac_nx    = r_ac;
        w_dr_nx    = r_dr;
        w_ir_nx    = r_ir;
        w_e_nx     = r_e;
        w_req_nx   = r_req;
        w_we_nx    = r_we;
        w_addr_nx  = r_addr;
        w_wdata_nx = r_wdata;
        w_go       = 1'b0;
        w_go_we    = 1'b0;
        w_go_addr  = r_ar;
        w_go_wdata = r_ac;
        case (r_state)
            S_FETCH: begin
                w_go      = en;
                w_go_addr = r_pc;
                if (w_ack) begin
                    w_ir_nx    = mem.mem_rdata;
                    w_pc_nx    = r_pc + ADDR_W'(1);
                    w_state_nx = S_DECODE;
                end
            end
            S_DECODE: begin
                w_ar_nx    = r_ir[ADDR_W-1:0];
                w_state_nx = (w_i && w_opc != OP_REG) ? S_INDIR : S_EXEC;
            end
            S_INDIR: begin
                w_go = 1'b1;
                if (w_ack) begin
                    w_ar_nx    = mem.mem_rdata[ADDR_W-1:0];
                    w_state_nx = S_EXEC;
                end
            end
            S_EXEC: begin
                case (w_opc)
                    OP_AND, OP_ADD, OP_LDA: begin
                        w_go = 1'b1;
                        if (w_ack) begin
                            w_ac_nx    = w_alu_ac;
                            w_e_nx     = w_alu_e;
                            w_state_nx = S_FETCH;
                        end
                    end
                    OP_STA: begin
                        w_go    = 1'b1;
                        w_go_we = 1'b1;
                        if (w_ack) w_state_nx = S_FETCH;
                    end
                    OP_BUN: begin
                        w_pc_nx    = r_ar;
                        w_state_nx = S_FETCH;
                    end
                    OP_BSA: begin
                        w_go       = 1'b1;
                        w_go_we    = 1'b1;
                        w_go_wdata = DATA_W'(r_pc);
                        if (w_ack) begin
                            w_pc_nx    = r_ar + ADDR_W'(1);
                            w_state_nx = S_FETCH;
                        end
                    end
                    OP_ISZ: begin
                        w_go = 1'b1;
                        if (w_ack) begin
                            w_dr_nx    = mem.mem_rdata + DATA_W'(1);
                            w_state_nx = S_WB;
                        end
                    end
                    default: begin
                        w_ac_nx    = w_alu_ac;
                        w_e_nx     = w_alu_e;
                        w_pc_nx    = w_skip ? r_pc + ADDR_W'(1) : r_pc;
                        w_state_nx = (!w_i && w_rr == RR_HLT) ? S_HALT : S_FETCH;
                    end
                endcase
            end
            S_WB: begin
                w_go       = 1'b1;
                w_go_we    = 1'b1;
                w_go_wdata = r_dr;
                if (w_ack) begin
                    w_pc_nx    = (r_dr == '0) ? r_pc + ADDR_W'(1) : r_pc;
                    w_state_nx = S_FETCH;
                end
            end
            default: ;
        endcase
        // A request, once raised, holds its address/data until acked; a new one starts a cycle later.
        if (w_ack) begin
            w_req_nx = 1'b0;
        end else if (w_go && !r_req) begin
            w_req_nx   = 1'b1;
            w_we_nx    = w_go_we;
            w_addr_nx  = w_go_addr;
            w_wdata_nx = w_go_wdata;
        end
        w_done_nx = (w_state_nx == S_FETCH) && (r_state != S_FETCH);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= S_FETCH;
            r_pc    <= RESET_PC;
            r_ar    <= '0;
            r_ac    <= '0;
            r_dr    <= '0;
            r_ir    <= '0;
            r_e     <= 1'b0;
            r_req   <= 1'b0;
            r_we    <= 1'b0;
            r_addr  <= '0;
            r_wdata <= '0;
            r_done  <= 1'b0;
        end else begin
            r_state <= w_state_nx;
            r_pc    <= w_pc_nx;
            r_ar    <= w_ar_nx;
            r_ac    <= w_ac_nx;
            r_dr    <= w_dr_nx;
            r_ir    <= w_ir_nx;
            r_e     <= w_e_nx;
            r_req   <= w_req_nx;
            r_we    <= w_we_nx;
            r_addr  <= w_addr_nx;
            r_wdata <= w_wdata_nx;
            r_done  <= w_done_nx;
        end
    end

    assign mem.mem_req   = r_req;
    assign mem.mem_we    = r_we;
    assign mem.mem_addr  = r_addr;
    assign mem.mem_wdata = r_wdata;
    assign ac_out        = r_ac;
    assign pc_out        = r_pc;
    assign e_out         = r_e;
    assign halted        = (r_state == S_HALT);
    assign instr_done    = r_done;
endmodule

// File: tb/tb_param_control_unit.sv
// tb_param_control_unit: directed programs against a 16/8 instance and a 24/12 instance,
// with a negedge memory responder that has a programmable ack delay.
module tb_param_control_unit;
    logic clk = 1'b0;
    logic reset = 1'b0;
    logic en = 1'b0;
    logic en24 = 1'b0;
    int   dly = 0;
    int   n_tests = 0;
    int   n_fail = 0;
    int   cnt, cnt24, n_rd, n_wr, rd0, wr0;
    logic [7:0]  last_wa;
    logic [15:0] last_wd;
    logic [15:0] mem [256];
    logic [23:0] m24 [4096];
    logic [15:0] ac16;
    logic [7:0]  pc16;
    logic        e16, halted16, done16;
    logic [23:0] ac24;
    logic [11:0] pc24;
    logic        e24, halted24, done24;

    always #5 clk = ~clk;

    param_control_unit_if #(.DATA_W(16), .ADDR_W(8)) bus ();
    param_control_unit_if #(.DATA_W(24), .ADDR_W(12)) bus24 ();

    param_control_unit #(.DATA_W(16), .ADDR_W(8), .RESET_PC(8'h00)) dut (
        .clk(clk), .reset(reset), .en(en), .mem(bus), .ac_out(ac16), .pc_out(pc16),
        .e_out(e16), .halted(halted16), .instr_done(done16)
    );

    param_control_unit #(.DATA_W(24), .ADDR_W(12), .RESET_PC(12'hFFF)) dut24 (
        .clk(clk), .reset(reset), .en(en24), .mem(bus24), .ac_out(ac24), .pc_out(pc24),
        .e_out(e24), .halted(halted24), .instr_done(done24)
    );

    always @(negedge clk) begin
        if (!reset || bus.mem_ack) begin
            bus.mem_ack = 1'b0;
            cnt = 0;
        end else if (bus.mem_req) begin
            if (cnt >= dly) begin
                bus.mem_ack = 1'b1;
                if (bus.mem_we) begin
                    n_wr++;
                    last_wa = bus.mem_addr;
                    last_wd = bus.mem_wdata;
                end else begin
                    n_rd++;
                    bus.mem_rdata = mem[bus.mem_addr];
                end
            end else cnt++;
        end
    end

    always @(negedge clk) begin
        if (!reset || bus24.mem_ack) begin
            bus24.mem_ack = 1'b0;
            cnt24 = 0;
        end else if (bus24.mem_req) begin
            if (cnt24 >= dly) begin
                bus24.mem_ack = 1'b1;
                bus24.mem_rdata = m24[bus24.mem_addr];
            end else cnt24++;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic wait_done(input bit big);
        for (int k = 0; k < 300; k++) begin
            @(posedge clk);
            #1;
            if (big ? done24 : done16) break;
        end
        chk(big ? "done24" : "done16", big ? 32'(done24) : 32'(done16), 32'd1);
    endtask

    task automatic wait_halt();
        for (int k = 0; k < 500; k++) begin
            @(posedge clk);
            #1;
            if (halted16) break;
        end
        chk("halt_reached", 32'(halted16), 32'd1);
    endtask

    task automatic clr();
        for (int i = 0; i < 256; i++) mem[i] = '0;
        for (int i = 0; i < 4096; i++) m24[i] = '0;
    endtask

    task automatic do_reset();
        reset = 1'b0;
        en = 1'b0;
        en24 = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b1;
        rd0 = n_rd;
        wr0 = n_wr;
    endtask

    initial begin
        n_rd = 0;
        n_wr = 0;
        clr();
        repeat (2) @(posedge clk);
        #1;
        chk("rst_pc", 32'(pc16), 32'h0);
        chk("rst_ac", 32'(ac16), 32'h0);
        chk("rst_e", 32'(e16), 32'h0);
        chk("rst_halted", 32'(halted16), 32'h0);
        chk("rst_done", 32'(done16), 32'h0);
        chk("rst_req", 32'(bus.mem_req), 32'h0);
        chk("rst_we", 32'(bus.mem_we), 32'h0);
        chk("rst_pc24", 32'(pc24), 32'hFFF);
        @(negedge clk);
        reset = 1'b1;
        repeat (5) @(posedge clk);
        #1;
        chk("idle_req", 32'(bus.mem_req), 32'h0);
        chk("idle_pc", 32'(pc16), 32'h0);

        // LDA/ADD/STA/HLT: 5 + 0xFFFD carries into E.
        clr();
        mem[0] = 16'h200A; mem[1] = 16'h100B; mem[2] = 16'h300C; mem[3] = 16'h7001;
        mem[10] = 16'h0005; mem[11] = 16'hFFFD;
        do_reset();
        en = 1'b1;
        wait_halt();
        chk("prog_wr_cnt", 32'(n_wr - wr0), 32'd1);
        chk("prog_wr_addr", 32'(last_wa), 32'h0C);
        chk("prog_wr_data", 32'(last_wd), 32'h0002);
        chk("prog_ac", 32'(ac16), 32'h0002);
        chk("prog_e", 32'(e16), 32'h1);
        chk("prog_pc", 32'(pc16), 32'h04);
        repeat (10) @(posedge clk);
        #1;
        chk("halt_stays", 32'(halted16), 32'h1);
        chk("halt_noreq", 32'(bus.mem_req), 32'h0);

        // Indirect LDA: fetch, pointer read, operand read.
        clr();
        mem[0] = 16'hA014; mem[20] = 16'h0030; mem[8'h30] = 16'h1234;
        do_reset();
        en = 1'b1;
        wait_done(1'b0);
        chk("ind_ac", 32'(ac16), 32'h1234);
        chk("ind_reads", 32'(n_rd - rd0), 32'd3);

        // ISZ wrapping to zero skips.
        clr();
        mem[0] = 16'h6005; mem[5] = 16'hFFFF;
        do_reset();
        en = 1'b1;
        wait_done(1'b0);
        chk("isz_pc", 32'(pc16), 32'h02);
        chk("isz_wr_cnt", 32'(n_wr - wr0), 32'd1);
        chk("isz_wr_addr", 32'(last_wa), 32'h05);
        chk("isz_wr_data", 32'(last_wd), 32'h0000);

        // BUN to 3, then BSA 0x40.
        clr();
        mem[0] = 16'h4003; mem[3] = 16'h5040;
        do_reset();
        en = 1'b1;
        wait_done(1'b0);
        chk("bun_pc", 32'(pc16), 32'h03);
        chk("bun_noreads", 32'(n_rd - rd0), 32'd1);
        wait_done(1'b0);
        chk("bsa_pc", 32'(pc16), 32'h41);
        chk("bsa_wr_addr", 32'(last_wa), 32'h40);
        chk("bsa_wr_data", 32'(last_wd), 32'h0004);

        // Register-reference sequence with skips, priority and reserved opcode.
        clr();
        mem[0] = 16'h2020; mem[1] = 16'h7080; mem[2] = 16'h7040; mem[3] = 16'h7200;
        mem[4] = 16'h7020; mem[5] = 16'h7A00; mem[6] = 16'h7100; mem[7] = 16'h7004;
        mem[8] = 16'h7001; mem[9] = 16'h7020; mem[10] = 16'h7008; mem[11] = 16'hF123;
        mem[12] = 16'h7001; mem[8'h20] = 16'h8001;
        do_reset();
        en = 1'b1;
        wait_done(1'b0);
        chk("rr_lda", 32'(ac16), 32'h8001);
        wait_done(1'b0);
        chk("rr_cir_ac", 32'(ac16), 32'h4000);
        chk("rr_cir_e", 32'(e16), 32'h1);
        wait_done(1'b0);
        chk("rr_cil_ac", 32'(ac16), 32'h8001);
        chk("rr_cil_e", 32'(e16), 32'h0);
        wait_done(1'b0);
        chk("rr_cma", 32'(ac16), 32'h7FFE);
        wait_done(1'b0);
        chk("rr_inc", 32'(ac16), 32'h7FFF);
        wait_done(1'b0);
        chk("rr_priority", 32'(ac16), 32'h0000);
        wait_done(1'b0);
        chk("rr_cme", 32'(e16), 32'h1);
        wait_done(1'b0);
        chk("rr_sza_skip", 32'(pc16), 32'h09);
        wait_done(1'b0);
        chk("rr_inc2", 32'(ac16), 32'h0001);
        wait_done(1'b0);
        chk("rr_sna_noskip", 32'(pc16), 32'h0B);
        rd0 = n_rd;
        wait_done(1'b0);
        chk("rsv_ac", 32'(ac16), 32'h0001);
        chk("rsv_pc", 32'(pc16), 32'h0C);
        chk("rsv_reads", 32'(n_rd - rd0), 32'd1);
        wait_halt();
        chk("rr_halt_pc", 32'(pc16), 32'h0D);

        // Reset during a delayed ack aborts the fetch.
        clr();
        mem[0] = 16'h2005;
        dly = 3;
        do_reset();
        en = 1'b1;
        for (int k = 0; k < 20; k++) begin
            @(posedge clk);
            #1;
            if (bus.mem_req) break;
        end
        chk("dly_req", 32'(bus.mem_req), 32'h1);
        @(negedge clk);
        #1;
        chk("dly_addr", 32'(bus.mem_addr), 32'h00);
        chk("dly_we", 32'(bus.mem_we), 32'h0);
        @(negedge clk);
        #1;
        chk("dly_req_held", 32'(bus.mem_req), 32'h1);
        reset = 1'b0;
        en = 1'b0;
        #1;
        chk("abort_req", 32'(bus.mem_req), 32'h0);
        chk("abort_pc", 32'(pc16), 32'h00);
        @(negedge clk);
        reset = 1'b1;
        repeat (6) @(posedge clk);
        #1;
        chk("late_ack_req", 32'(bus.mem_req), 32'h0);
        chk("late_ack_reads", 32'(n_rd - rd0), 32'd0);
        chk("late_ack_pc", 32'(pc16), 32'h00);
        chk("late_ack_ac", 32'(ac16), 32'h0);
        dly = 0;

        // 24/12 instance: PC wrap from 0xFFF, then CIL through E.
        clr();
        m24[12'hFFF] = 24'h700000; m24[0] = 24'h200010; m24[1] = 24'h700040; m24[16] = 24'h800000;
        do_reset();
        en24 = 1'b1;
        wait_done(1'b1);
        chk("w24_pc_wrap", 32'(pc24), 32'h000);
        wait_done(1'b1);
        chk("w24_lda", 32'(ac24), 32'h800000);
        wait_done(1'b1);
        chk("w24_cil_ac", 32'(ac24), 32'h000000);
        chk("w24_cil_e", 32'(e24), 32'h1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/param_control_unit.md
PARAM_CONTROL_UNIT -- requirements
Module: param_control_unit

Interface
REQ-001 Parameter DATA_W, default 16, is the word width; legal range is 16 or more.
REQ-002 Parameter ADDR_W, default 8, is the address width; legal range is 4 to DATA_W-4.
REQ-003 Parameter RESET_PC, default 0, is the PC value loaded at reset.
REQ-004 Port clk, input, 1 bit: single clock; all state updates on rising edge.
REQ-005 Port reset, input, 1 bit: reset, asynchronous, active-low.
REQ-006 Port en, input, 1 bit: run enable, sampled only in FETCH.
REQ-007 Port mem_req, output, 1 bit: memory request, held until ack.
REQ-008 Port mem_we, output, 1 bit: 1 means write, 0 means read; valid while mem_req=1.
REQ-009 Port mem_addr, output, ADDR_W bits: memory address.
REQ-010 Port mem_wdata, output, DATA_W bits: write data.
REQ-011 Port mem_rdata, input, DATA_W bits: read data, valid in the mem_ack cycle.
REQ-012 Port mem_ack, input, 1 bit: single-cycle completion; ignored when mem_req=0.
REQ-013 Ports ac_out (DATA_W bits), pc_out (ADDR_W bits), e_out (1 bit), outputs: architectural AC, PC and E.
REQ-014 Ports halted (1 bit) and instr_done (1 bit), outputs: halted is high in HALT; instr_done pulses for 1 cycle on each transition into FETCH.

Function
REQ-015 Instruction format: I = IR[DATA_W-1]; opcode = IR[DATA_W-2:DATA_W-4]; address = IR[ADDR_W-1:0].
REQ-016 FSM states: FETCH, DECODE, INDIR, EXEC, WB, HALT.
REQ-017 FETCH:
- when en=0: no request issued; stay in FETCH.
- when en=1: read M[PC]; on ack, IR<=rdata, PC<=PC+1 modulo 2^ADDR_W, go to DECODE.
REQ-018 DECODE:
- AR<=address field.
- Go to INDIR if I=1 and opcode!=7; otherwise go to EXEC.
REQ-019 INDIR: read M[AR]; on ack, AR<=rdata[ADDR_W-1:0], go to EXEC.
REQ-020 EXEC, memory-reference opcodes:
- 0 AND: read; AC<=AC&rdata.
- 1 ADD: read; {E,AC}<=AC+rdata (carry to E).
- 2 LDA: read; AC<=rdata.
- 3 STA: write AC to M[AR].
- 4 BUN: PC<=AR, one cycle, no memory access.
- 5 BSA: write zero-extended PC to M[AR]; on ack, PC<=AR+1.
- 6 ISZ: read; DR<=rdata+1; go to WB.
- All except ISZ return to FETCH on completion.
REQ-021 WB (ISZ only): write DR to M[AR]; on ack, PC<=PC+1 if DR==0, then go to FETCH.
REQ-022 Opcode 7 with I=0 (register reference), one EXEC cycle, using IR bits 11..0:
- 11 CLA, 10 CLE, 9 CMA, 8 CME.
- 7 CIR: AC<={E,AC[MSB:1]}, E<=AC[0].
- 6 CIL: rotate left through E.
- 5 INC: AC+1 wraps; E unchanged.
- 4 SPA, 3 SNA, 2 SZA, 1 SZE: skip sets PC<=PC+1 when the condition is true.
- 0 HLT: go to HALT.
REQ-023 If more than one register-reference bit is set, only the highest-numbered set bit executes; if none is set, the instruction is a NOP.
REQ-024 Opcode 7 with I=1 is reserved and executes as a one-cycle NOP.
REQ-025 HALT is left only by reset; mem_req=0 while in HALT.
REQ-026 mem_addr, mem_we and mem_wdata are stable from mem_req rise through the ack cycle; mem_req falls in the cycle after ack.
REQ-027 An unbounded ack delay stalls the FSM indefinitely with no timeout; en changes during an instruction have no effect until FETCH.

Reset
REQ-028 While reset=0: PC=RESET_PC; AC, DR, IR, AR and E all 0; state=FETCH; mem_req=0; mem_we=0; halted=0; instr_done=0.
REQ-029 Reset asserted mid-transaction aborts it immediately; the pending ack is not waited for.

Structure
REQ-030 Shared package cu_pkg holds the state enum, the opcode constants and the register-reference bit indices.
REQ-031 Sub-module cu_alu is purely combinational: inputs AC, operand, E and operation; outputs new AC and new E; parametrised by DATA_W.

Verification
REQ-032 Program at 0: 0x200A, 0x100B, 0x300C, 0x7001, with M[10]=0x0005 and M[11]=0xFFFD -> M[12]=0x0002, E=1, halted=1, pc_out=4.
REQ-033 0xA014 with M[20]=0x0030 and M[0x30]=0x1234 -> AC=0x1234, exactly 3 read transactions.
REQ-034 M[5]=0xFFFF, 0x6005 at PC 0 -> M[5]=0x0000, pc_out=2.
REQ-035 BSA 0x5040 at PC 3 -> M[0x40]=0x0004, pc_out=0x41.
REQ-036 mem_ack delayed 3 cycles, then reset pulled low during the wait -> mem_req=0 and pc_out=RESET_PC within the same cycle; the late ack is ignored.
REQ-037 With DATA_W=24 and ADDR_W=12, PC=0xFFF fetching a NOP -> pc_out=0x000; CIL with AC=0x800000 and E=0 -> AC=0x000000, E=1.
